irs_pedestal_scan_ctrl: RTL and testbench

Hardware sequencer for IRS pedestal acquisition. It sits between the IRS WISHBONE control registers and the IRS pedestal/trigger datapath. It steps the pedestal address over a programmed range and, at each address, strobes a pedestal sample, waits a settle time, issues N software triggers, and waits for readout completion after each. It replaces per-address software writes to the pedestal control and address registers.

---
 rtl/irs_ped_scan_pkg.sv | 17 +
 rtl/irs_ped_timer.sv | 38 +++
 rtl/irs_pedestal_scan_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_irs_pedestal_scan_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/irs_ped_scan_pkg.sv
// Shared constants for the IRS pedestal scan sequencer: state encoding and field widths.
package irs_ped_scan_pkg;

    localparam int PED_ADDR_BITS = 9;
    localparam int TRIG_IDX_BITS = 8;
    localparam int TIMER_BITS    = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SAMPLE = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_TRIG   = 3'd4;
    localparam logic [2:0] ST_WAIT   = 3'd5;
    localparam logic [2:0] ST_NEXT   = 3'd6;
    localparam logic [2:0] ST_FINISH = 3'd7;

endpackage

// File: rtl/irs_ped_timer.sv
// Loadable down counter shared by the settle delay and the readout timeout.
// Holds at zero; load has priority over decrement.
module irs_ped_timer
    import irs_ped_scan_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic [TIMER_BITS-1:0] val_i,
    input  logic                  en_i,
    output logic                  zero_o,
    output logic [TIMER_BITS-1:0] cnt_o
);

    logic [TIMER_BITS-1:0] cnt_q;
    logic [TIMER_BITS-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - TIMER_BITS'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/irs_pedestal_scan_ctrl.sv
// IRS pedestal scan sequencer: walks the pedestal address over a latched range, sampling
// once per address and issuing a programmable number of software triggers per address.
module irs_pedestal_scan_ctrl
    import irs_ped_scan_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic        INFO_TAG       = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [PED_ADDR_BITS-1:0] first_addr_i,
    input  logic [PED_ADDR_BITS-1:0] last_addr_i,
    input  logic [TRIG_IDX_BITS-1:0] trigs_i,
    input  logic [7:0]               settle_i,
    input  logic                     readout_done_i,
    output logic                     ped_mode_o,
    output logic [PED_ADDR_BITS-1:0] ped_addr_o,
    output logic                     ped_sample_o,
    output logic                     soft_trig_o,
    output logic [7:0]               soft_trig_info_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o,
    output logic [2:0]               dbg_state_o
);

    // Control flags (start, abort, readout_done, sample, trigger, done) are single-cycle
    // pulses with no back-pressure; each strobe output is registered on entry to its state.
    logic [2:0]               state_q, state_d;
    logic [PED_ADDR_BITS-1:0] first_q, first_d;
    logic [PED_ADDR_BITS-1:0] last_q, last_d;
    logic [TRIG_IDX_BITS-1:0] trigs_q, trigs_d;
    logic [7:0]               settle_q, settle_d;
    logic [PED_ADDR_BITS-1:0] addr_q, addr_d;
    logic [TRIG_IDX_BITS-1:0] trig_idx_q, trig_idx_d;
    logic                     mode_q, mode_d;
    logic                     sample_q, sample_d;
    logic                     trig_q, trig_d;
    logic [7:0]               info_q, info_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;

    logic                     tmr_load;
    logic [TIMER_BITS-1:0]    tmr_val;
    logic                     tmr_en;
    logic                     tmr_zero;
    logic [TIMER_BITS-1:0]    tmr_cnt;
    logic [TRIG_IDX_BITS:0]   trigs_eff;
    logic [TRIG_IDX_BITS:0]   trig_next;

    irs_ped_timer u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (tmr_load),
        .val_i  (tmr_val),
        .en_i   (tmr_en),
        .zero_o (tmr_zero),
        .cnt_o  (tmr_cnt)
    );

    // A programmed trigger count of zero still fires once per address.
    assign trigs_eff = (trigs_q == '0) ? 9'd1 : {1'b0, trigs_q};
    assign trig_next = {1'b0, trig_idx_q} + 9'd1;

    always_comb begin
        state_d    = state_q;
        first_d    = first_q;
        last_d     = last_q;
        trigs_d    = trigs_q;
        settle_d   = settle_q;
        addr_d     = addr_q;
        trig_idx_d = trig_idx_q;
        mode_d     = mode_q;
        sample_d   = 1'b0;
        trig_d     = 1'b0;
        info_d     = info_q;
        done_d     = 1'b0;
        error_d    = error_q;
        tmr_load   = 1'b0;
        tmr_val    = {8'd0, settle_q};
        tmr_en     = 1'b0;

        if ((state_q != ST_IDLE) && abort_i) begin
            state_d = ST_IDLE;
            mode_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        first_d  = first_addr_i;
                        last_d   = last_addr_i;
                        trigs_d  = trigs_i;
                        settle_d = settle_i;
                        error_d  = 1'b0;
                        state_d  = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    addr_d     = first_q;
                    trig_idx_d = '0;
                    mode_d     = 1'b1;
                    sample_d   = 1'b1;
                    state_d    = ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    tmr_load = 1'b1;
                    state_d  = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (tmr_zero) begin
                        trig_d  = 1'b1;
                        info_d  = {INFO_TAG, trig_idx_q[6:0]};
                        state_d = ST_TRIG;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_TRIG: begin
                    tmr_load = 1'b1;
                    tmr_val  = TIMEOUT_CYCLES - 16'd1;
                    state_d  = ST_WAIT;
                end
                ST_WAIT: begin
                    // Expiry is the cycle whose decrement would reach zero, so the error
                    // flag surfaces TIMEOUT_CYCLES cycles after the trigger strobe.
                    if (readout_done_i) begin
                        state_d = ST_NEXT;
                    end else if (tmr_cnt <= 16'd1) begin
                        error_d = 1'b1;
                        mode_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                ST_NEXT: begin
                    if (trig_next < trigs_eff) begin
                        trig_idx_d = trig_idx_q + 8'd1;
                        tmr_load   = 1'b1;
                        state_d    = ST_SETTLE;
                    end else if (addr_q == last_q) begin
                        done_d  = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        addr_d     = addr_q + 9'd1;
                        trig_idx_d = '0;
                        sample_d   = 1'b1;
                        state_d    = ST_SAMPLE;
                    end
                end
                ST_FINISH: begin
                    mode_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    mode_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            first_q    <= '0;
            last_q     <= '0;
            trigs_q    <= '0;
            settle_q   <= '0;
            addr_q     <= '0;
            trig_idx_q <= '0;
            mode_q     <= 1'b0;
            sample_q   <= 1'b0;
            trig_q     <= 1'b0;
            info_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            last_q     <= last_d;
            trigs_q    <= trigs_d;
            settle_q   <= settle_d;
            addr_q     <= addr_d;
            trig_idx_q <= trig_idx_d;
            mode_q     <= mode_d;
            sample_q   <= sample_d;
            trig_q     <= trig_d;
            info_q     <= info_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign ped_mode_o       = mode_q;
    assign ped_addr_o       = addr_q;
    assign ped_sample_o     = sample_q;
    assign soft_trig_o      = trig_q;
    assign soft_trig_info_o = info_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign error_o          = error_q;
    assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_irs_pedestal_scan_ctrl.sv
// Bench for irs_pedestal_scan_ctrl: expected strobe timelines are derived from the scan
// rules (address order, trigger counts, latency arithmetic) and compared cycle by cycle.
module tb_irs_pedestal_scan_ctrl;
    import irs_ped_scan_pkg::*;

    localparam int TMO  = 100;
    localparam int MAXC = 4096;

    logic       clk;
    logic       rst_i;
    logic       start_i;
    logic       abort_i;
    logic [8:0] first_addr_i;
    logic [8:0] last_addr_i;
    logic [7:0] trigs_i;
    logic [7:0] settle_i;
    logic       readout_done_i;
    logic       ped_mode_o;
    logic [8:0] ped_addr_o;
    logic       ped_sample_o;
    logic       soft_trig_o;
    logic [7:0] soft_trig_info_o;
    logic       busy_o;
    logic       done_o;
    logic       error_o;
    logic [2:0] dbg_state_o;

    int n_checks;
    int n_fail;

    bit  samp_at [MAXC];
    bit  trig_at [MAXC];
    bit  rd_at   [MAXC];
    bit  wait_at [MAXC];
    int  samp_addr [MAXC];
    logic [16:0] exp_q[$];
    bit  err_prev;

    irs_pedestal_scan_ctrl #(
        .TIMEOUT_CYCLES (16'(TMO)),
        .INFO_TAG       (1'b1)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .abort_i          (abort_i),
        .first_addr_i     (first_addr_i),
        .last_addr_i      (last_addr_i),
        .trigs_i          (trigs_i),
        .settle_i         (settle_i),
        .readout_done_i   (readout_done_i),
        .ped_mode_o       (ped_mode_o),
        .ped_addr_o       (ped_addr_o),
        .ped_sample_o     (ped_sample_o),
        .soft_trig_o      (soft_trig_o),
        .soft_trig_info_o (soft_trig_info_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .error_o          (error_o),
        .dbg_state_o      (dbg_state_o)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Expected timeline, relative to the start cycle (0):
    // first trigger at settle+4; readout at r -> repeat trigger r+settle+3,
    // new address sample at r+2 and trigger r+settle+4, done at r+2.
    task automatic build_model(input int f, input int l, input int tr, input int st,
                               input int to_k, input int abort_c, input int fix_d,
                               output int idle_c, output int done_c, output int err_c);
        int ntr, a, t, j, k, r, d, ntrunc;
        for (int i = 0; i < MAXC; i++) begin
            samp_at[i] = 0; trig_at[i] = 0; rd_at[i] = 0; wait_at[i] = 0; samp_addr[i] = 0;
        end
        exp_q.delete();
        ntr = (tr == 0) ? 1 : tr;
        a = f; j = 0; k = 0; t = st + 4;
        idle_c = -1; done_c = -1; err_c = -1;
        samp_at[2] = 1; samp_addr[2] = a;
        while (idle_c < 0) begin
            trig_at[t] = 1;
            exp_q.push_back({a[8:0], 1'b1, j[6:0]});
            k++;
            if (k == to_k) begin
                err_c  = t + TMO;
                idle_c = err_c;
                for (int i = t + 1; i < err_c; i++) wait_at[i] = 1;
            end else begin
                if (fix_d > 0) d = fix_d;
                else if ($urandom_range(0, 4) == 0) d = TMO - 1;
                else d = int'($urandom_range(1, 40));
                r = t + d;
                rd_at[r] = 1;
                for (int i = t + 1; i <= r; i++) wait_at[i] = 1;
                if (j + 1 < ntr) begin
                    j++;
                    t = r + 3 + st;
                end else if (a == l) begin
                    done_c = r + 2;
                    idle_c = r + 3;
                end else begin
                    a = (a + 1) % 512;
                    j = 0;
                    samp_at[r + 2] = 1; samp_addr[r + 2] = a;
                    t = r + 4 + st;
                end
            end
        end
        if (abort_c > 0 && abort_c < idle_c) begin
            ntrunc = 0;
            for (int i = abort_c + 1; i < MAXC; i++) begin
                if (trig_at[i]) ntrunc++;
                samp_at[i] = 0; trig_at[i] = 0; rd_at[i] = 0; wait_at[i] = 0;
            end
            repeat (ntrunc) void'(exp_q.pop_back());
            idle_c = abort_c + 1;
            if (done_c > abort_c) done_c = -1;
            if (err_c > abort_c) err_c = -1;
        end
    endtask

    task automatic run_scan(input int f, input int l, input int tr, input int st,
                            input int to_k, input int abort_c, input int fix_d, input bit noise);
        int idle_c, done_c, err_c;
        logic [5:0]  got_v, exp_v;
        logic [16:0] e;
        build_model(f, l, tr, st, to_k, abort_c, fix_d, idle_c, done_c, err_c);
        for (int c = 0; c <= idle_c + 3; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                start_i      = 1'b1;
                first_addr_i = f[8:0];
                last_addr_i  = l[8:0];
                trigs_i      = tr[7:0];
                settle_i     = st[7:0];
            end else begin
                start_i = noise && (c < idle_c) && ($urandom_range(0, 9) == 0);
                if (noise) begin
                    first_addr_i = 9'($urandom);
                    last_addr_i  = 9'($urandom);
                    trigs_i      = 8'($urandom);
                    settle_i     = 8'($urandom);
                end
            end
            readout_done_i = rd_at[c] || (noise && !wait_at[c] && ($urandom_range(0, 3) == 0));
            abort_i = (c == abort_c);
            @(negedge clk);
            got_v = {busy_o, ped_mode_o, ped_sample_o, soft_trig_o, done_o, error_o};
            exp_v[5] = (c >= 1) && (c < idle_c);
            exp_v[4] = (c >= 2) && (c < idle_c);
            exp_v[3] = samp_at[c];
            exp_v[2] = trig_at[c];
            exp_v[1] = (c == done_c);
            exp_v[0] = (c == 0) ? err_prev : ((err_c >= 0) && (c >= err_c));
            chk("strobes", 32'(got_v), 32'(exp_v));
            if (samp_at[c]) chk("sample_addr", 32'(ped_addr_o), samp_addr[c]);
            if (soft_trig_o) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("trig_addr_info", 32'({ped_addr_o, soft_trig_info_o}), 32'(e));
                end else begin
                    chk("trig_extra", 32'(soft_trig_o), 32'd0);
                end
            end
        end
        chk("trig_left", exp_q.size(), 0);
        err_prev       = (err_c >= 0);
        start_i        = 1'b0;
        abort_i        = 1'b0;
        readout_done_i = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; err_prev = 1'b0;
        rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; readout_done_i = 1'b0;
        first_addr_i = '0; last_addr_i = '0; trigs_i = '0; settle_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("rst_strobes", 32'({busy_o, ped_mode_o, ped_sample_o, soft_trig_o, done_o, error_o}), 32'd0);
        chk("rst_addr", 32'(ped_addr_o), 32'd0);
        chk("rst_info", 32'(soft_trig_info_o), 32'd0);
        chk("rst_state", 32'(dbg_state_o), 32'(ST_IDLE));

        run_scan(5, 7, 2, 3, -1, -1, 10, 1'b0);       // basic scan
        run_scan(510, 1, 0, 2, -1, -1, 0, 1'b0);      // address wrap, trigs=0
        run_scan(20, 22, 1, 2, 1, -1, 0, 1'b0);       // timeout on first trigger
        run_scan(30, 31, 2, 0, -1, -1, TMO - 1, 1'b0); // readout on expiry cycle; start clears error
        run_scan(40, 41, 1, 200, -1, 10, 0, 1'b1);    // abort in a long settle
        run_scan(50, 51, 1, 5, -1, 8, 0, 1'b0);       // abort suppresses the pending trigger

        for (int n = 0; n < 10; n++) begin
            int f, l, tr, st, tk, ab;
            f  = int'($urandom_range(0, 511));
            l  = (f + int'($urandom_range(0, 3))) % 512;
            tr = int'($urandom_range(0, 3));
            st = int'($urandom_range(0, 15));
            tk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : -1;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
            run_scan(f, l, tr, st, tk, ab, 0, 1'b1);
        end

        // Reset while waiting for readout
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            start_i = (c == 0);
            first_addr_i = 9'd100; last_addr_i = 9'd100; trigs_i = 8'd1; settle_i = 8'd1;
            readout_done_i = 1'b0;
            rst_i = (c == 7);
            @(negedge clk);
            if (c == 5) chk("rstw_trig", 32'(soft_trig_o), 32'd1);
            if (c == 8) begin
                chk("rstw_strobes", 32'({busy_o, ped_mode_o, ped_sample_o, soft_trig_o, done_o, error_o}), 32'd0);
                chk("rstw_addr_info", 32'({ped_addr_o, soft_trig_info_o}), 32'd0);
            end
        end
        rst_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
